// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider and its period meter.
// Holds the default geometry, the meter FSM encoding and the sel-to-period map.
package clkdiv_pkg;

  localparam int DEF_LOG2_MAX = 16;
  localparam int DEF_SEL_W    = 3;
  localparam int DEF_CNT_W    = 18;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURE    = 2'd1,
    TIMEOUT    = 2'd2
  } meter_state_e;

  // Period in system clocks that a given divider select produces.
  function automatic logic [31:0] sel_to_period(input int unsigned log2_max,
                                                input int unsigned sel);
    return 32'd1 << (log2_max - sel);
  endfunction

endpackage

// File: rtl/clkdiv_meter_if.sv
// Measurement control and result bundle of the divided-clock period meter.
// Optional macro CLKDIV_METER_LOCK_EN adds the locked_o indication.
interface clkdiv_meter_if
  import clkdiv_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             en_i;
  logic             sig_i;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic [SEL_W-1:0] sel_o;
  logic             match_o;
  logic             timeout_o;
`ifdef CLKDIV_METER_LOCK_EN
  logic             locked_o;

  modport master (output en_i, sig_i,
                  input  period_o, valid_o, sel_o, match_o, timeout_o, locked_o);
  modport slave  (input  en_i, sig_i,
                  output period_o, valid_o, sel_o, match_o, timeout_o, locked_o);
`else
  modport master (output en_i, sig_i,
                  input  period_o, valid_o, sel_o, match_o, timeout_o);
  modport slave  (input  en_i, sig_i,
                  output period_o, valid_o, sel_o, match_o, timeout_o);
`endif

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, followed by a delay flop
// that turns the synchronized level into a one-cycle rising-edge strobe.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_sig,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Bring the asynchronous level into the clk domain and keep a delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_sig};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

endmodule

// File: rtl/clkdiv_meter.sv
// Divided-clock period meter: counts clk_i cycles between rising edges of
// sig_i, reports the period, decodes the divider select that produces it and
// flags a stuck input with a sticky timeout.
// Optional macro CLKDIV_METER_LOCK_EN adds a three-in-a-row lock indication.
module clkdiv_meter
  import clkdiv_pkg::*;
#(
  parameter int LOG2_MAX = DEF_LOG2_MAX,
  parameter int SEL_W    = DEF_SEL_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  clkdiv_meter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  meter_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic [SEL_W-1:0] sel_q;
  logic             match_q;
  logic             timeout_q;
  logic             en_d;
  logic             rise;
  logic             dec_match;
  logic [SEL_W-1:0] dec_sel;
`ifdef CLKDIV_METER_LOCK_EN
  logic [1:0]       lock_cnt;
  logic             locked_q;
`endif

  sync_edge_det u_edge (
    .clk       (clk_i),
    .rst       (rst_i),
    .async_sig (bus.sig_i),
    .rise      (rise)
  );

  // Decode the running count as a legal divider period; the count at the
  // closing edge is the period being reported.
  always_comb begin
    dec_match = 1'b0;
    dec_sel   = '0;
    for (int s = 0; s < 2**SEL_W; s++) begin
      if (32'(cnt) == sel_to_period(LOG2_MAX, s)) begin
        dec_match = 1'b1;
        dec_sel   = SEL_W'(s);
      end
    end
  end

  // Measurement FSM with the period counter and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= WAIT_FIRST;
      cnt       <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      sel_q     <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      en_d      <= 1'b0;
`ifdef CLKDIV_METER_LOCK_EN
      lock_cnt  <= 2'd0;
      locked_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      en_d    <= bus.en_i;
      if (!bus.en_i) begin
        state <= WAIT_FIRST;
        cnt   <= '0;
        if (en_d) begin
          timeout_q <= 1'b0;
        end
`ifdef CLKDIV_METER_LOCK_EN
        lock_cnt <= 2'd0;
        locked_q <= 1'b0;
`endif
      end else begin
        case (state)
          WAIT_FIRST: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (cnt == CNT_MAX) begin
              timeout_q <= 1'b1;
              state     <= TIMEOUT;
`ifdef CLKDIV_METER_LOCK_EN
              lock_cnt  <= 2'd0;
              locked_q  <= 1'b0;
`endif
            end else if (rise) begin
              period_q <= cnt;
              valid_q  <= 1'b1;
              cnt      <= CNT_W'(1);
              match_q  <= dec_match;
              if (dec_match) begin
                sel_q <= dec_sel;
              end
`ifdef CLKDIV_METER_LOCK_EN
              if (dec_match && (dec_sel == sel_q)) begin
                lock_cnt <= (lock_cnt == 2'd3) ? 2'd3 : 2'(lock_cnt + 2'd1);
                locked_q <= (lock_cnt >= 2'd2);
              end else begin
                lock_cnt <= dec_match ? 2'd1 : 2'd0;
                locked_q <= 1'b0;
              end
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TIMEOUT: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= MEASURE;
            end
          end
          default: begin
            state <= WAIT_FIRST;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period_o  = period_q;
  assign bus.valid_o   = valid_q;
  assign bus.sel_o     = sel_q;
  assign bus.match_o   = match_q;
  assign bus.timeout_o = timeout_q;
`ifdef CLKDIV_METER_LOCK_EN
  assign bus.locked_o  = locked_q;
`endif

endmodule

// File: doc/clkdiv_meter.md
Name: clkdiv_meter

Overview:
- Measures the period, in clk_i cycles, of a divided clock fed back into the fabric.
- Decodes the divider select that would produce that period, using the relation period = 2^(LOG2_MAX - sel).
- Sits on the receive side of the clock divider: it is the in-circuit checker used by self-test logic and by the status register bank.

Parameters:
- LOG2_MAX, 16, log2 of the largest divide ratio (sel = 0).
- SEL_W, 3, width of the decoded select; valid sel values are 0 .. 2^SEL_W-1.
- CNT_W, 18, period counter width; must be at least LOG2_MAX+2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- en_i  in  1  measurement enable; when low, the FSM is held in WAIT_FIRST.
- sig_i  in  1  measured divided clock, treated as asynchronous.
- period_o  out  CNT_W  last measured period in clk_i cycles.
- valid_o  out  1  one-cycle pulse when period_o updates.
- sel_o  out  SEL_W  decoded select; updates only on a match.
- match_o  out  1  last period equals 2^(LOG2_MAX-s) for some legal s.
- timeout_o  out  1  sticky; no edge was seen within 2^CNT_W-1 cycles.

Behaviour:
- Reset values: period_o=0, valid_o=0, sel_o=0, match_o=0, timeout_o=0, cnt=0, state=WAIT_FIRST. Synchronizer flops reset to 0.
- sig_i passes through a 2-flop synchronizer followed by a delay flop. A rising edge is detected as (sync=1 and prev=0). Edge-detect latency from sig_i to the internal edge strobe is 3 clk_i cycles; this latency is constant, so it does not affect the measured period.
- FSM WAIT_FIRST:
  - On an edge with en_i=1: cnt<=1, go to MEASURE.
  - No output update.
- FSM MEASURE:
  - Each cycle, cnt<=cnt+1.
  - On an edge: period_o<=cnt, valid_o=1 for the next cycle, cnt<=1, stay in MEASURE.
  - The measured value equals the exact clk_i cycle count between consecutive rising edges.
- Decode, registered in the same cycle as period_o: if period == 2^k with k in [LOG2_MAX-(2^SEL_W-1) .. LOG2_MAX], then sel_o<=LOG2_MAX-k and match_o<=1. Otherwise match_o<=0 and sel_o holds its value.
- Saturation: when cnt reaches 2^CNT_W-1 in MEASURE, set timeout_o<=1 and go to TIMEOUT; period_o is unchanged and there is no valid pulse.
- FSM TIMEOUT: the next edge gives cnt<=1 and a transition to MEASURE; nothing is reported for that edge.
- timeout_o clears only on reset or on a falling edge of en_i.
- Edge in the same cycle as saturation: the timeout takes priority; go to TIMEOUT, report nothing, and the next edge restarts measurement.
- en_i deasserted in any state: next state is WAIT_FIRST and cnt<=0. The outputs hold their last values.
- Reset mid-measurement: everything returns to reset values immediately (asynchronous). The first period after reset is never reported; at least two edges are required.
- Minimum measurable period is 2 cycles, because a pulse must be high for at least 1 synchronized cycle and low for 1.

Optional Feature:
- Macro: CLKDIV_METER_LOCK_EN. When defined, adds output locked_o and a 2-bit consecutive-match counter.
- On each valid_o: if match_o=1 and the new sel equals the previous sel_o, the counter increments, saturating at 3. Otherwise it reloads to 1 if match_o=1, or to 0 if not.
- locked_o=1 while the counter is 3, i.e. three consecutive identical matched periods.
- Timeout or en_i low clears the counter and locked_o.
- When the macro is undefined, the port and logic are absent and the behaviour above is unchanged.

Decomposition:
- Shared package clkdiv_pkg holds:
  - LOG2_MAX, SEL_W and CNT_W defaults;
  - the FSM state encoding (WAIT_FIRST=2'd0, MEASURE=2'd1, TIMEOUT=2'd2);
  - a function mapping sel to the expected period.
- The divider itself and this block both use the package.
- Sub-module: sync_edge_det (2-flop synchronizer plus rising-edge strobe), which is reusable elsewhere.
- The period counter, decode and FSM stay in clkdiv_meter.

Test Plan:
- Reset is asserted and released; sig_i toggles with a period of 65536 cycles. Required: valid_o is first seen after the second edge, with period_o=65536, sel_o=0, match_o=1.
- Sweep sel 0..7 on a real divider instance (period 10 ns). Required:
  - period_o = 2^(16-sel), i.e. 65536, 32768, ... 512;
  - sel_o tracks sel;
  - valid_o is exactly 1 cycle wide.
- sig_i with a period of 1000 cycles. Required: period_o=1000, match_o=0, sel_o keeps its prior value.
- Stop sig_i (held at 0) for longer than 262143 cycles. Required: timeout_o=1 with no valid_o pulse. Restart at 512 cycles: the first reported period is 512 after two edges, and timeout_o stays 1 until en_i toggles.
- Assert rst_i mid-period, then drop en_i for 100 cycles. Required: all outputs return to 0 asynchronously, and there is no report until two edges occur after re-enable.
- With CLKDIV_METER_LOCK_EN defined: three 4096-cycle periods give locked_o=1 and sel_o=4. One 4095-cycle period then gives locked_o=0 on the same valid_o cycle.
